binary_mul_rr_sched: RTL and testbench

//  Shares one iterative signed multiplier (A_W x A_W -> P_W, fixed LATENCY, en-gated) among NREQ requesters.

---
 rtl/binary_mul_sched_pkg.sv | 18 +
 rtl/binary_mul_rr_sched_arb.sv | 31 +++
 rtl/binary_mul_rr_sched.sv | 164 ++++++++++++++++
 tb/tb_binary_mul_rr_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_mul_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// Optional build macro used by the top: MUL_SCHED_ZERO_BYPASS_EN.
package binary_mul_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int A_W_DEF     = 11;
   localparam int LATENCY_DEF = 12;

   function automatic int p_w(input int a_w);
      return 2*a_w - 1;
   endfunction

endpackage

// File: rtl/binary_mul_rr_sched_arb.sv
// Combinational rotating-priority arbiter: the search starts one past ptr
// and wraps, so the last-served requester has the lowest priority.
module rr_arbiter_onehot #(
   parameter  int NREQ = 4,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt
);

   // One extra bit so ptr + k never overflows before the modulo fold.
   logic [ID_W:0] w_sum;
   logic          w_found;

   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_sum   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NREQ)) w_sum = w_sum - (ID_W+1)'(NREQ);
         if (en && !w_found && req[w_sum[ID_W-1:0]]) begin
            gnt[w_sum[ID_W-1:0]] = 1'b1;
            w_found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/binary_mul_rr_sched.sv
// Round-robin scheduler sharing one external fixed-latency signed multiplier.
// Build macro MUL_SCHED_ZERO_BYPASS_EN: zero operands skip the multiplier.
module binary_mul_rr_sched
   import binary_mul_sched_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int A_W     = A_W_DEF,
   parameter  int LATENCY = LATENCY_DEF,
   localparam int P_W     = p_w(A_W),
   localparam int ID_W    = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*A_W-1:0] req_a,
   input  logic [NREQ*A_W-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [ID_W-1:0]     rsp_id,
   output logic [P_W-1:0]      rsp_p,
   output logic                mul_en,
   output logic [A_W-1:0]      mul_a,
   output logic [A_W-1:0]      mul_b,
   input  logic [P_W-1:0]      mul_p
);

   localparam int                CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LATENCY - 1);

   state_t           r_state,     w_state_nxt;
   logic [ID_W-1:0]  r_ptr,       w_ptr_nxt;
   logic [ID_W-1:0]  r_rsp_id,    w_rsp_id_nxt;
   logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
   logic [A_W-1:0]   r_mul_a,     w_mul_a_nxt;
   logic [A_W-1:0]   r_mul_b,     w_mul_b_nxt;
   logic             r_mul_en,    w_mul_en_nxt;
   logic             r_rsp_valid, w_rsp_valid_nxt;
   logic [P_W-1:0]   r_rsp_p,     w_rsp_p_nxt;

   logic [NREQ-1:0]  w_gnt;
   logic [ID_W-1:0]  w_gnt_idx;
   logic [A_W-1:0]   w_sel_a;
   logic [A_W-1:0]   w_sel_b;
   logic             w_arb_en;
   logic             w_hs;
   logic             w_load;

   // Grants only when the result slot is free or being drained this cycle;
   // gated by rst_n so req_ready reads 0 while reset is held.
   assign w_arb_en = rst_n & ((r_state == IDLE) |
                              ((r_state == DONE) & r_rsp_valid & rsp_ready));

   rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (r_ptr),
      .en  (w_arb_en),
      .gnt (w_gnt)
   );

   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_gnt[i]) w_gnt_idx = ID_W'(i);
   end

   assign w_sel_a = req_a[w_gnt_idx*A_W +: A_W];
   assign w_sel_b = req_b[w_gnt_idx*A_W +: A_W];
   assign w_hs    = |(req_valid & w_gnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= ID_W'(NREQ - 1);
         r_rsp_id    <= '0;
         r_cnt       <= '0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_mul_en    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_p     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_rsp_id    <= w_rsp_id_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mul_a     <= w_mul_a_nxt;
         r_mul_b     <= w_mul_b_nxt;
         r_mul_en    <= w_mul_en_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_p     <= w_rsp_p_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_rsp_id_nxt    = r_rsp_id;
      w_cnt_nxt       = r_cnt;
      w_mul_a_nxt     = r_mul_a;
      w_mul_b_nxt     = r_mul_b;
      w_mul_en_nxt    = r_mul_en;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_p_nxt     = r_rsp_p;
      w_load          = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_hs) w_load = 1'b1;
         end
         RUN: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST) begin
               w_rsp_p_nxt     = mul_p;
               w_mul_en_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = DONE;
            end
         end
         DONE: begin
`ifdef MUL_SCHED_ZERO_BYPASS_EN
            // A bypassed op enters DONE with valid low; raise it one cycle later.
            if (!r_rsp_valid) begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_p_nxt     = '0;
            end else
`endif
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               if (w_hs) w_load      = 1'b1;
               else      w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_load) begin
         w_rsp_id_nxt = w_gnt_idx;
         w_ptr_nxt    = w_gnt_idx;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
         if (w_sel_a == '0 || w_sel_b == '0) begin
            w_rsp_valid_nxt = 1'b0;
            w_state_nxt     = DONE;
         end else
`endif
         begin
            w_mul_a_nxt  = w_sel_a;
            w_mul_b_nxt  = w_sel_b;
            w_mul_en_nxt = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = RUN;
         end
      end
   end

   assign req_ready = w_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_p     = r_rsp_p;
   assign mul_en    = r_mul_en;
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_binary_mul_rr_sched.sv
// Directed bench for binary_mul_rr_sched with a behavioural LATENCY-cycle
// multiplier; honours MUL_SCHED_ZERO_BYPASS_EN for expected latencies.
module tb_binary_mul_rr_sched;

   localparam int NREQ    = 4;
   localparam int A_W     = 11;
   localparam int LATENCY = 12;
   localparam int P_W     = 2*A_W - 1;
   localparam int ID_W    = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*A_W-1:0] req_a;
   logic [NREQ*A_W-1:0] req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [P_W-1:0]      rsp_p;
   logic                mul_en;
   logic [A_W-1:0]      mul_a;
   logic [A_W-1:0]      mul_b;
   logic [P_W-1:0]      mul_p;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   binary_mul_rr_sched #(.NREQ(NREQ), .A_W(A_W), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .mul_en    (mul_en),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p)
   );

   // Multiplier model: product is only presented once mul_en has been seen
   // high on LATENCY-1 edges; otherwise a recognisable junk value.
   int                     mcnt;
   logic signed [2*A_W-1:0] mfull;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 mcnt <= 0;
      else if (!mul_en)           mcnt <= 0;
      else if (mcnt < LATENCY-1)  mcnt <= mcnt + 1;
   end
   assign mfull = $signed(mul_a) * $signed(mul_b);
   assign mul_p = (mcnt == LATENCY-1) ? mfull[P_W-1:0] : 21'h0AAAA;

   typedef struct {
      int id;
      int a;
      int b;
      int p;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input int a, input int b);
`ifdef MUL_SCHED_ZERO_BYPASS_EN
      return (a == 0 || b == 0) ? 1 : LATENCY;
`else
      return LATENCY;
`endif
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_ops(input int id, input int a, input int b);
      req_a[id*A_W +: A_W] = A_W'(a);
      req_b[id*A_W +: A_W] = A_W'(b);
   endtask

   // Single requester op: handshake, measure latency, check id/product, drain.
   task automatic run_op(input string nm, input int id, input int a,
                         input int b, input int p);
      bit ok, got, seen_en;
      int lat;
      @(negedge clk);
      set_ops(id, a, b);
      req_valid[id] = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (req_ready[id]) ok = 1;
         else @(negedge clk);
      end
      chk({nm, "_grant"}, ok, 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      seen_en = mul_en;
      lat = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         seen_en |= mul_en;
         if (rsp_valid) got = 1;
      end
      chk({nm, "_lat"}, lat, exp_lat(a, b));
      chk({nm, "_id"}, rsp_id, id);
      chk({nm, "_p"}, $signed(rsp_p), p);
      chk({nm, "_en"}, seen_en, (exp_lat(a, b) == 1) ? 0 : 1);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({nm, "_drain"}, rsp_valid, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int ord[5];
      int cyc, prev, g, pos2, ea, eb, ep;
      bit got, stable;
      logic [P_W-1:0] hold_p;
      logic [ID_W-1:0] hold_id;

      tbl[0] = '{0,     3,    -5,      -15};
      tbl[1] = '{1,  1023, -1024, -1047552};
      tbl[2] = '{2, -1024, -1024, -1048576};
      tbl[3] = '{3,    -1,    -1,        1};
      tbl[4] = '{1,     0,   777,        0};
      tbl[5] = '{2, -1024,  1023, -1047552};

      // Reset state
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      #12;
      chk("reset_outs", longint'({req_ready, rsp_valid, rsp_id, rsp_p,
                                  mul_en, mul_a, mul_b}), 0);
      do_reset();

      for (int i = 0; i < 6; i++)
         run_op($sformatf("vec%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p);

      // All four requesting with rsp_ready=1: order 0,1,2,3,0, 13-cycle spacing
      do_reset();
      ord = '{0, 1, 2, 3, 0};
      set_ops(0, 1023, -1024);
      set_ops(1, 7, 9);
      set_ops(2, -100, 200);
      set_ops(3, -1024, -1024);
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      cyc = 0; prev = -1;
      for (int n = 0; n < 5; n++) begin
         got = 0;
         for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid) got = 1;
         end
         case (ord[n])
            0:       ep = -1047552;
            1:       ep = 63;
            2:       ep = -20000;
            default: ep = -1048576;
         endcase
         chk($sformatf("rr_id%0d", n), rsp_id, ord[n]);
         chk($sformatf("rr_p%0d", n), $signed(rsp_p), ep);
         if (n > 0) chk($sformatf("rr_gap%0d", n), cyc - prev, LATENCY + 1);
         prev = cyc;
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      // rsp_ready held low in DONE; new op accepted the cycle it rises
      do_reset();
      set_ops(0, 12, -12);
      set_ops(1, -300, 300);
      req_valid = 4'b0011;
      #1;
      chk("hold_first_gnt", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) got = 1;
      end
      chk("hold_p", $signed(rsp_p), -144);
      hold_p = rsp_p; hold_id = rsp_id;
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_p !== hold_p || rsp_id !== hold_id || req_ready !== '0)
            stable = 0;
      end
      chk("hold_stable", stable, 1);
      rsp_ready = 1'b1;
      #1;
      chk("hold_release_gnt", req_ready, 4'b0010);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid[1] = 1'b0;
      chk("hold_drained", rsp_valid, 0);
      cyc = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (rsp_valid) got = 1;
      end
      chk("hold_next_lat", cyc, LATENCY);
      chk("hold_next_id", rsp_id, 1);
      chk("hold_next_p", $signed(rsp_p), -90000);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset while RUN is at cnt=5
      do_reset();
      set_ops(0, 5, 5);
      req_valid = 4'b0001;
      @(posedge clk); #1;
      req_valid = 4'b0010;
      set_ops(1, 2, 2);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", longint'({req_ready, rsp_valid, rsp_id, rsp_p,
                                    mul_en, mul_a, mul_b}), 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      got = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) got = 1;
      end
      chk("rst_no_stale", got, 0);
      run_op("post_rst", 0, 3, -5, -15);

      // Requester 2 waits while 0 and 1 compete; operands scrambled after grant
      do_reset();
      run_op("prime2", 2, 4, 4, 16);
      set_ops(0, 100, -3);
      set_ops(1, -7, -8);
      set_ops(2, 2, -1024);
      req_valid = 4'b0111;
      rsp_ready = 1'b1;
      ord = '{0, 1, 2, 0, 0};
      pos2 = NREQ;
      for (int n = 0; n < 3; n++) begin
         got = 0;
         for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            if (|(req_valid & req_ready)) got = 1;
         end
         chk($sformatf("fair_gnt%0d", n), got, 1);
         g = 0;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
         ea = $signed(req_a[g*A_W +: A_W]);
         eb = $signed(req_b[g*A_W +: A_W]);
         ep = ea * eb;
         if (g == 2) pos2 = n;
         @(posedge clk); #1;
         req_valid[g] = 1'b0;
         set_ops(g, 511, 511);
         stable = 1; got = 0;
         for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if ($signed(mul_a) != ea || $signed(mul_b) != eb) stable = 0;
            if (rsp_valid) got = 1;
         end
         chk($sformatf("fair_opstable%0d", n), stable, 1);
         chk($sformatf("fair_id%0d", n), rsp_id, ord[n]);
         chk($sformatf("fair_p%0d", n), $signed(rsp_p), ep);
      end
      chk("fair_req2_within_nreq", pos2 < NREQ, 1);
      rsp_ready = 1'b0;
      req_valid = '0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
